// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register ids, status codes
// and the writeback FSM state type.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam int NUM_REGS = 15;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } wb_state_e;

  // Status of one instruction: memory faults outrank decode faults, which
  // outrank a normal halt.
  function automatic logic [2:0] instr_status(input logic mem_err,
                                              input logic instruct_err,
                                              input logic [3:0] icode);
    logic [2:0] s;
    s = STAT_AOK;
    if (mem_err)
      s = STAT_ADR;
    else if (instruct_err)
      s = STAT_INS;
    else if (icode == I_HALT)
      s = STAT_HLT;
    return s;
  endfunction

endpackage

// File: rtl/regfile.sv
// 15 x 64-bit register file: two combinational read ports, two write ports.
// Port M wins when both write the same register.
module regfile
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] val_a,
  output logic [63:0] val_b,
  input  logic        we_e,
  input  logic [3:0]  dst_e,
  input  logic [63:0] data_e,
  input  logic        we_m,
  input  logic [3:0]  dst_m,
  input  logic [63:0] data_m
);

  logic [63:0] regs_q [NUM_REGS];

  // RNONE has no storage behind it, so it reads as zero.
  assign val_a = (src_a == RNONE) ? 64'd0 : regs_q[src_a];
  assign val_b = (src_b == RNONE) ? 64'd0 : regs_q[src_b];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= 64'd0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_m && dst_m == 4'(i))
          regs_q[i] <= data_m;
        else if (we_e && dst_e == 4'(i))
          regs_q[i] <= data_e;
      end
    end
  end

endmodule

// File: rtl/writeback.sv
// Y86-64 writeback stage: destination selection, commit/stop FSM, retired
// instruction counter, and the register file it commits into.
module writeback
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        mem_err,
  input  logic        instruct_err,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] val_a,
  output logic [63:0] val_b,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic [2:0]  stat,
  output logic        halted,
  output logic [63:0] retired
);

  wb_state_e   state_q, state_d;
  logic [2:0]  stop_stat_q, stop_stat_d;
  logic [63:0] retired_q, retired_d;
  logic [2:0]  stat_c;
  logic        commit;
  logic        unused_ifun;

  assign unused_ifun = ^ifun;

  always_comb begin
    dstE = RNONE;
    case (icode)
      I_RRMOVQ:                         dstE = cnd ? rb : RNONE;
      I_IRMOVQ, I_OPQ:                  dstE = rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:   dstE = RRSP;
      default:                          dstE = RNONE;
    endcase
  end

  always_comb begin
    dstM = RNONE;
    if (icode == I_MRMOVQ || icode == I_POPQ)
      dstM = ra;
  end

  assign stat_c = instr_status(mem_err, instruct_err, icode);

  // Only a clean instruction in RUN commits; a faulting one stops the machine
  // without touching architectural state.
  assign commit = en && (state_q == ST_RUN) && (stat_c == STAT_AOK);

  always_comb begin
    state_d     = state_q;
    stop_stat_d = stop_stat_q;
    retired_d   = retired_q;
    if (commit) begin
      retired_d = retired_q + 64'd1;
    end else if (en && state_q == ST_RUN) begin
      state_d     = ST_STOP;
      stop_stat_d = stat_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      stop_stat_q <= STAT_AOK;
      retired_q   <= 64'd0;
    end else begin
      state_q     <= state_d;
      stop_stat_q <= stop_stat_d;
      retired_q   <= retired_d;
    end
  end

  always_comb begin
    stat = STAT_AOK;
    if (state_q == ST_STOP)
      stat = stop_stat_q;
    else if (en)
      stat = stat_c;
  end

  assign halted  = (state_q == ST_STOP);
  assign retired = retired_q;

  regfile u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .src_a  (src_a),
    .src_b  (src_b),
    .val_a  (val_a),
    .val_b  (val_b),
    .we_e   (commit && (dstE != RNONE)),
    .dst_e  (dstE),
    .data_e (valE),
    .we_m   (commit && (dstM != RNONE)),
    .dst_m  (dstM),
    .data_m (valM)
  );

endmodule
